ti_unmask_s4: RTL and testbench
===============================

TI_UNMASK_S4 -- requirements
Module: ti_unmask_s4

Interface
REQ-001 Parameter: W, 4, bit width of one share and of the recombined output nibble.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  shared word present on in_sh.
REQ-005 Port: in_ready  output  1  block accepts in_sh this cycle.
REQ-006 Port: in_sh  input  3*W  three TI output shares; share0 = [W-1:0], share1 = [2W-1:W], share2 = [3W-1:2W].
REQ-007 Port: out_valid  output  1  recombined nibble present on out.
REQ-008 Port: out_ready  input  1  downstream accepts out this cycle.
REQ-009 Port: out  output  W  unmasked value, share0 ^ share1 ^ share2.
REQ-010 Port: busy  output  1  high while any pipeline stage holds valid data.

Function
REQ-011 Transfer in: in_valid & in_ready on a rising edge; transfer out: out_valid & out_ready.
REQ-012 Stage 1 shall register all three shares unmodified, with no XOR ahead of the register (glitch barrier between the TI share functions and recombination).
REQ-013 Stage 2 shall register share0 ^ share1 ^ share2 computed from stage-1 registers only.
REQ-014 Latency: accepted word appears on out exactly 2 cycles after acceptance when out_ready stays high.
REQ-015 Throughput: one word per cycle sustained while out_ready is high; no bubbles inserted.
REQ-016 in_ready = !s1_valid | s1 advances this cycle; s1 advances when !s2_valid | out_ready.
REQ-017 Backpressure: with out_ready low, stage 2 and stage 1 hold their contents; at most 2 words buffered, then in_ready deasserts.
REQ-018 in_ready shall not depend combinationally on in_valid.
REQ-019 out and out_valid shall be driven straight from stage-2 registers.
REQ-020 out_valid, once asserted, shall stay high with out stable until the transfer completes.
REQ-021 Simultaneous in-transfer and out-transfer on a full pipeline shall move both stages without loss or duplication.
REQ-022 in_sh is ignored when in_valid is low; stage registers are not updated with don't-care data.
REQ-023 busy = s1_valid | s2_valid.

Reset
REQ-024 While rst is high at a clock edge: s1_valid = 0, s2_valid = 0, out = 0, share registers = 0, counter (if built) = 0.
REQ-025 During and on the cycle after reset: out_valid = 0, busy = 0, in_ready = 1.
REQ-026 Reset asserted mid-stream shall discard all in-flight words; none emerge afterwards.

Configuration
REQ-027 Macro TI_UNMASK_CNT_EN defined: extra output port done_cnt (output, 16 bits) counting completed out-transfers, wrapping 0xFFFF -> 0x0000, reset to 0.
REQ-028 Macro TI_UNMASK_CNT_EN undefined: done_cnt port and counter logic are absent; all other behaviour identical.

Verification
REQ-029 Reset then in_sh = 0x9A3 (shares 3, A, 9), in_valid 1 cycle, out_ready=1 -> out_valid at +2 cycles, out = 0x0 ^ ... = 3^A^9 = 0x0 for... check: 3^A=9, 9^9=0 -> out = 0x0.
REQ-030 Stream shares 0x001, 0x020, 0x300, 0x124 back-to-back, out_ready=1 -> out = 1, 2, 3, 7 on 4 consecutive cycles starting 2 cycles after the first.
REQ-031 out_ready=0, drive 3 words -> first 2 accepted, in_ready low on third; raise out_ready -> all 3 emerge in order, out held stable while stalled.
REQ-032 Full pipeline, out_ready=1 and in_valid=1 same cycle -> one word out, one in, busy stays 1, no loss.
REQ-033 Assert rst with 2 words in flight -> out_valid=0, busy=0 next cycle, no stale word later.
REQ-034 With TI_UNMASK_CNT_EN: preload 65535 transfers (or force counter) then one more -> done_cnt = 0x0000.

Source files
------------

// File: rtl/ti_unmask_s4.sv
// Two-stage recombination of three TI shares with a glitch-barrier register.
// Define TI_UNMASK_CNT_EN to add the done_cnt out-transfer counter.
module ti_unmask_s4 #(
   parameter int W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [3*W-1:0] in_sh,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W-1:0]   out,
   output logic           busy
`ifdef TI_UNMASK_CNT_EN
   ,
   output logic [15:0]    done_cnt
`endif
);

   logic           s1_valid;
   logic [3*W-1:0] s1_sh;
   logic           s1_adv;
   logic [W-1:0]   recomb;

   assign s1_adv   = !out_valid | out_ready;
   assign in_ready = !s1_valid | s1_adv;
   assign busy     = s1_valid | out_valid;

   // Recombine only from registered shares, never from in_sh directly.
   assign recomb = s1_sh[W-1:0] ^ s1_sh[2*W-1:W] ^ s1_sh[3*W-1:2*W];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_sh     <= '0;
         out_valid <= 1'b0;
         out       <= '0;
      end else begin
         if (in_ready) begin
            s1_valid <= in_valid;
         end
         if (in_valid && in_ready) begin
            s1_sh <= in_sh;
         end
         if (s1_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out <= recomb;
            end
         end
      end
   end

`ifdef TI_UNMASK_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         done_cnt <= 16'h0000;
      end else if (out_valid && out_ready) begin
         done_cnt <= done_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_ti_unmask_s4.sv
// Bench for ti_unmask_s4: vector table, directed stall/reset sequences,
// and random traffic against a queue-based reference model.
module tb_ti_unmask_s4;

   localparam int W = 4;

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [3*W-1:0] in_sh;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out;
   logic           busy;
`ifdef TI_UNMASK_CNT_EN
   logic [15:0]    done_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   ti_unmask_s4 #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sh     (in_sh),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .busy      (busy)
`ifdef TI_UNMASK_CNT_EN
      ,
      .done_cnt  (done_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic           iv;
      logic [3*W-1:0] sh;
      logic           ordy;
      logic           exp_ov;
      logic [W-1:0]   exp_out;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Apply inputs away from the clock edge and let combinational outputs settle.
   task automatic cyc(input logic iv, input logic [3*W-1:0] sh,
                      input logic ordy);
      @(negedge clk);
      in_valid  = iv;
      in_sh     = sh;
      out_ready = ordy;
      #1;
   endtask

   function automatic logic [W-1:0] xr(input logic [3*W-1:0] s);
      return s[3:0] ^ s[7:4] ^ s[11:8];
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out", 32'(out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
   endtask

   logic [W-1:0] q[$];
   logic         hold_pend;
   logic [W-1:0] hold_val;
   logic         iv_r, or_r;

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_sh = '0;
      out_ready = 1'b1;

      // Single word, then a 4-word back-to-back burst.
      vecs[0]  = '{1'b1, 12'h9A3, 1'b1, 1'b0, 4'h0};
      vecs[1]  = '{1'b0, 12'hFFF, 1'b1, 1'b0, 4'h0};
      vecs[2]  = '{1'b0, 12'h000, 1'b1, 1'b1, 4'h0};
      vecs[3]  = '{1'b0, 12'h000, 1'b1, 1'b0, 4'h0};
      vecs[4]  = '{1'b1, 12'h001, 1'b1, 1'b0, 4'h0};
      vecs[5]  = '{1'b1, 12'h020, 1'b1, 1'b0, 4'h0};
      vecs[6]  = '{1'b1, 12'h300, 1'b1, 1'b1, 4'h1};
      vecs[7]  = '{1'b1, 12'h124, 1'b1, 1'b1, 4'h2};
      vecs[8]  = '{1'b0, 12'h555, 1'b1, 1'b1, 4'h3};
      vecs[9]  = '{1'b0, 12'h000, 1'b1, 1'b1, 4'h7};
      vecs[10] = '{1'b0, 12'h000, 1'b1, 1'b0, 4'h0};
      vecs[11] = '{1'b0, 12'h000, 1'b1, 1'b0, 4'h0};

      do_reset();

      for (int i = 0; i < 12; i++) begin
         cyc(vecs[i].iv, vecs[i].sh, vecs[i].ordy);
         chk($sformatf("vec%0d_ov", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         if (vecs[i].exp_ov)
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
         chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      end

      // Backpressure: two words buffered, third refused, then drain in order.
      cyc(1'b1, 12'h001, 1'b0);
      chk("bp_accept0", 32'(in_ready), 32'd1);
      cyc(1'b1, 12'h050, 1'b0);
      chk("bp_accept1", 32'(in_ready), 32'd1);
      cyc(1'b1, 12'h600, 1'b0);
      chk("bp_refuse2", 32'(in_ready), 32'd0);
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_out0", 32'(out), 32'h1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 12'h600, 1'b0);
         chk("bp_hold_ov", 32'(out_valid), 32'd1);
         chk("bp_hold_out", 32'(out), 32'h1);
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
      end
      // Full pipeline: one word out and one in on the same edge.
      cyc(1'b1, 12'h600, 1'b1);
      chk("full_in_ready", 32'(in_ready), 32'd1);
      chk("full_out0", 32'(out), 32'h1);
      cyc(1'b0, 12'h000, 1'b1);
      chk("full_busy", 32'(busy), 32'd1);
      chk("full_out1", 32'(out), 32'h5);
      cyc(1'b0, 12'h000, 1'b1);
      chk("full_ov2", 32'(out_valid), 32'd1);
      chk("full_out2", 32'(out), 32'h6);
      cyc(1'b0, 12'h000, 1'b1);
      chk("drain_ov", 32'(out_valid), 32'd0);
      chk("drain_busy", 32'(busy), 32'd0);

      // Reset with two words in flight discards both.
      cyc(1'b1, 12'h00A, 1'b0);
      cyc(1'b1, 12'h0B0, 1'b0);
      cyc(1'b0, 12'h000, 1'b0);
      chk("flight_busy", 32'(busy), 32'd1);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 12'h000, 1'b1);
         chk("no_stale_ov", 32'(out_valid), 32'd0);
      end

      // Random traffic against a queue of expected recombined values.
      hold_pend = 1'b0;
      hold_val = '0;
      for (int i = 0; i < 3000; i++) begin
         iv_r = ($urandom_range(0, 3) != 0);
         or_r = ($urandom_range(0, 2) != 0);
         cyc(iv_r, 12'($urandom), or_r);
         chk("rnd_in_ready", 32'(in_ready),
             32'((q.size() < 2) || or_r));
         chk("rnd_busy", 32'(busy), 32'(q.size() != 0));
         if (q.size() == 0)
            chk("rnd_ov_empty", 32'(out_valid), 32'd0);
         if (hold_pend) begin
            chk("rnd_hold_ov", 32'(out_valid), 32'd1);
            chk("rnd_hold_out", 32'(out), 32'(hold_val));
         end
         hold_pend = out_valid && !out_ready;
         hold_val = out;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("rnd_spurious", 32'd1, 32'd0);
            end else begin
               chk("rnd_out", 32'(out), 32'(q[0]));
               void'(q.pop_front());
            end
         end
         if (in_valid && in_ready)
            q.push_back(xr(in_sh));
      end
      for (int i = 0; i < 10 && q.size() != 0; i++) begin
         cyc(1'b0, 12'h000, 1'b1);
         if (out_valid) begin
            chk("rnd_drain_out", 32'(out), 32'(q[0]));
            void'(q.pop_front());
         end
      end
      chk("rnd_drain_empty", 32'(q.size()), 32'd0);

`ifdef TI_UNMASK_CNT_EN
      do_reset();
      chk("cnt_reset", 32'(done_cnt), 32'd0);
      for (int i = 0; i < 65535; i++) cyc(1'b1, 12'h111, 1'b1);
      cyc(1'b0, 12'h000, 1'b1);
      cyc(1'b0, 12'h000, 1'b1);
      cyc(1'b0, 12'h000, 1'b1);
      chk("cnt_ffff", 32'(done_cnt), 32'hFFFF);
      cyc(1'b1, 12'h111, 1'b1);
      cyc(1'b0, 12'h000, 1'b1);
      cyc(1'b0, 12'h000, 1'b1);
      cyc(1'b0, 12'h000, 1'b1);
      chk("cnt_wrap", 32'(done_cnt), 32'h0000);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
